// File: rtl/mult_pkg.sv
// Shared widths, defaults and sequencer state encoding for the shared multiplier datapath.
package mult_pkg;
  localparam int OP_W      = 8;
  localparam int PDT_W     = 16;
  localparam int N_REQ_DEF = 4;
  localparam int ID_W_DEF  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/carry_save_mult.sv
// Combinational unsigned 8x8 multiplier: partial products folded through a
// 3:2 carry-save chain, resolved by one final carry-propagate add.
module carry_save_mult
  import mult_pkg::*;
(
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  output logic [PDT_W-1:0] p
);

  logic [PDT_W-1:0] sum_v;
  logic [PDT_W-1:0] carry_v;
  logic [PDT_W-1:0] pp;
  logic [PDT_W-1:0] sum_n;

  always_comb begin
    sum_v   = b[0] ? PDT_W'(a) : '0;
    carry_v = '0;
    pp      = '0;
    sum_n   = '0;
    for (int i = 1; i < OP_W; i++) begin
      pp      = b[i] ? (PDT_W'(a) << i) : '0;
      sum_n   = sum_v ^ carry_v ^ pp;
      // The dropped MSB of the shifted carry is always zero: the true product fits in PDT_W.
      carry_v = ((sum_v & carry_v) | (sum_v & pp) | (carry_v & pp)) << 1;
      sum_v   = sum_n;
    end
    p = sum_v + carry_v;
  end

endmodule

// File: rtl/mult_share_arb.sv
// Round-robin arbiter and IDLE/CALC/RESP sequencer sharing one carry_save_mult
// between N_REQ requesters, returning tagged products over a valid/ready channel.
//
//   state | meaning
//   IDLE  | offer a round-robin grant; accept latches operands and owner id
//   CALC  | sample the multiplier into res_pdt
//   RESP  | present result, hold until res_ready
module mult_share_arb
  import mult_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int ID_W  = ID_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [OP_W*N_REQ-1:0]   req_a,
  input  logic [OP_W*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    res_valid,
  output logic [ID_W-1:0]         res_id,
  output logic [PDT_W-1:0]        res_pdt,
  input  logic                    res_ready,
  output logic                    busy,
  output logic [15:0]             op_count
);

  state_t           state;
  state_t           state_nxt;
  logic [ID_W-1:0]  last_grant;
  logic [OP_W-1:0]  op_a;
  logic [OP_W-1:0]  op_b;
  logic [PDT_W-1:0] mult_p;
  logic [ID_W:0]    pick;
  logic             grant_ok;
  logic [ID_W-1:0]  grant_id;

  // Returns {found, index}; the lowest offset past 'last' wins.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] valid,
                                            input logic [ID_W-1:0]  last);
    logic [ID_W:0] r;
    r = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      int j;
      j = (int'(last) + off) % N_REQ;
      if (valid[j]) r = {1'b1, j[ID_W-1:0]};
    end
    return r;
  endfunction

  assign pick     = rr_pick(req_valid, last_grant);
  assign grant_ok = pick[ID_W];
  assign grant_id = pick[ID_W-1:0];

  carry_save_mult u_mult (
    .a (op_a),
    .b (op_b),
    .p (mult_p)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_ok) state_nxt = CALC;
      CALC:    state_nxt = RESP;
      RESP:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_ok) req_ready[grant_id] = 1'b1;
    res_valid = (state == RESP);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= ID_W'(N_REQ - 1);
      op_a       <= '0;
      op_b       <= '0;
      res_id     <= '0;
      res_pdt    <= '0;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: if (grant_ok) begin
          op_a       <= req_a[int'(grant_id)*OP_W +: OP_W];
          op_b       <= req_b[int'(grant_id)*OP_W +: OP_W];
          res_id     <= grant_id;
          last_grant <= grant_id;
        end
        CALC: res_pdt <= mult_p;
        RESP: if (res_ready) op_count <= op_count + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arb.sv
// Self-checking bench for mult_share_arb: transaction-level model compared every
// cycle, plus directed scenarios with hand-computed products and grant orders.
module tb_mult_share_arb;
  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [8*N-1:0] req_a = '0;
  logic [8*N-1:0] req_b = '0;
  logic [N-1:0]  req_ready;
  logic          res_valid;
  logic [IW-1:0] res_id;
  logic [15:0]   res_pdt;
  logic          res_ready = 1'b0;
  logic          busy;
  logic [15:0]   op_count;

  mult_share_arb #(.N_REQ(N), .ID_W(IW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .res_valid(res_valid), .res_id(res_id), .res_pdt(res_pdt),
    .res_ready(res_ready), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction model: one job in flight, visible as a result two cycles after acceptance.
  bit          m_fly = 0;
  int          m_age = 0;
  int          m_id = 0, m_a = 0, m_b = 0;
  int          m_last = N - 1;
  logic [15:0] m_count = '0;
  int          cyc = 0;
  int          h_id[$], h_pdt[$], h_cyc[$], g_cyc[$];

  function automatic int rr(input logic [N-1:0] v, input int last);
    for (int o = 1; o <= N; o++) begin
      int j;
      j = (last + o) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    int g;
    int exp_rdy;
    bit exp_val;
    cyc++;
    if (rst) begin
      chk("rst_res_valid", int'(res_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_req_ready", int'(req_ready), 0);
      chk("rst_op_count", int'(op_count), 0);
      chk("rst_res_id", int'(res_id), 0);
      chk("rst_res_pdt", int'(res_pdt), 0);
      m_fly = 0; m_age = 0; m_last = N - 1; m_count = '0;
    end else begin
      g       = m_fly ? -1 : rr(req_valid, m_last);
      exp_rdy = (g >= 0) ? (1 << g) : 0;
      exp_val = m_fly && m_age >= 2;
      chk("req_ready", int'(req_ready), exp_rdy);
      chk("res_valid", int'(res_valid), int'(exp_val));
      chk("busy", int'(busy), int'(m_fly));
      chk("op_count", int'(op_count), int'(m_count));
      if (exp_val) begin
        chk("res_id", int'(res_id), m_id);
        chk("res_pdt", int'(res_pdt), m_a * m_b);
      end
      if (g >= 0) begin
        m_fly = 1; m_age = 1; m_id = g; m_last = g;
        m_a = int'(req_a[8*g +: 8]);
        m_b = int'(req_b[8*g +: 8]);
        g_cyc.push_back(cyc);
      end else if (exp_val && res_ready) begin
        h_id.push_back(m_id); h_pdt.push_back(m_a * m_b); h_cyc.push_back(cyc);
        m_count = m_count + 16'd1;
        m_fly = 0;
      end else if (m_fly) begin
        m_age++;
      end
    end
  end

  task automatic set_req(input int k, input int a, input int b);
    req_a[8*k +: 8] = 8'(a);
    req_b[8*k +: 8] = 8'(b);
    req_valid[k]    = 1'b1;
  endtask

  task automatic req_until_grant(input int k, input int a, input int b);
    bit got;
    got = 0;
    set_req(k, a, b);
    for (int t = 0; t < 60 && !got; t++) begin
      @(negedge clk);
      if (req_ready[k]) got = 1;
    end
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    chk("grant_seen", int'(got), 1);
  endtask

  task automatic wait_hs(input int target);
    int t;
    t = 0;
    while (h_pdt.size() < target && t < 300) begin
      @(posedge clk); t++;
    end
    #1;
    chk("hs_count", h_pdt.size(), target);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int base;
    int ids[5];
    int pdts[5];
    ids  = '{0, 1, 2, 3, 0};
    pdts = '{855, 6063, 2448, 10672, 855};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // single requester
    res_ready = 1'b1;
    req_until_grant(0, 23, 14);
    wait_hs(1);
    chk("single_pdt", h_pdt[0], 322);
    chk("single_id", h_id[0], 0);
    chk("single_latency", h_cyc[0] - g_cyc[0], 2);
    @(negedge clk);
    chk("single_count", int'(op_count), 1);

    // fairness from a fresh pointer
    do_reset();
    base = h_pdt.size();
    set_req(0, 45, 19); set_req(1, 129, 47); set_req(2, 34, 72); set_req(3, 92, 116);
    wait_hs(base + 5);
    req_valid = '0;
    for (int i = 0; i < 5; i++) begin
      chk("fair_id", h_id[base+i], ids[i]);
      chk("fair_pdt", h_pdt[base+i], pdts[i]);
      if (i > 0) chk("fair_spacing", h_cyc[base+i] - h_cyc[base+i-1], 3);
    end

    // backpressure, with a competing request that must stay ungranted
    res_ready = 1'b0;
    base = h_pdt.size();
    req_until_grant(1, 157, 42);
    set_req(2, 3, 5);
    repeat (12) @(negedge clk);
    chk("bp_valid", int'(res_valid), 1);
    chk("bp_pdt", int'(res_pdt), 6594);
    chk("bp_id", int'(res_id), 1);
    chk("bp_ready", int'(req_ready), 0);
    chk("bp_busy", int'(busy), 1);
    chk("bp_no_hs", h_pdt.size(), base);
    @(posedge clk); #1 res_ready = 1'b1;
    @(posedge clk); #1 res_ready = 1'b0;
    @(negedge clk);
    chk("bp_one_hs", h_pdt.size(), base + 1);
    chk("bp_hs_pdt", h_pdt[base], 6594);
    res_ready = 1'b1;
    wait_hs(base + 2);
    req_valid = '0;
    chk("bp_next_pdt", h_pdt[base+1], 15);

    // boundary operands
    base = h_pdt.size();
    req_until_grant(3, 255, 255);
    req_until_grant(0, 0, 200);
    req_until_grant(2, 231, 24);
    wait_hs(base + 3);
    chk("bnd_max", h_pdt[base], 65025);
    chk("bnd_zero", h_pdt[base+1], 0);
    chk("bnd_mid", h_pdt[base+2], 5544);

    // reset while the result is presented
    res_ready = 1'b0;
    base = h_pdt.size();
    req_until_grant(2, 10, 10);
    for (int t = 0; t < 10 && !res_valid; t++) @(negedge clk);
    chk("rr_pre_valid", int'(res_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("rr_valid0", int'(res_valid), 0);
    chk("rr_busy0", int'(busy), 0);
    chk("rr_pdt0", int'(res_pdt), 0);
    chk("rr_id0", int'(res_id), 0);
    chk("rr_cnt0", int'(op_count), 0);
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    chk("rr_no_hs", h_pdt.size(), base);
    set_req(2, 6, 7); set_req(0, 8, 9);
    res_ready = 1'b1;
    wait_hs(base + 1);
    req_valid[0] = 1'b0;
    wait_hs(base + 2);
    req_valid = '0;
    chk("rr_first_id", h_id[base], 0);
    chk("rr_first_pdt", h_pdt[base], 72);
    chk("rr_second_id", h_id[base+1], 2);

    // counter wrap
    @(posedge clk); #1;
    force dut.op_count = 16'hFFFF;
    m_count = 16'hFFFF;
    #1 release dut.op_count;
    @(negedge clk);
    chk("wrap_pre", int'(op_count), 65535);
    base = h_pdt.size();
    req_until_grant(1, 2, 3);
    wait_hs(base + 1);
    @(negedge clk);
    chk("wrap_post", int'(op_count), 0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
